mem_ctrl: RTL and testbench

Parametrised multi-channel memory controller that serialises 1/2/4-byte load/store requests from `NCH` requesters onto the byte-wide external memory bus (`mem_din`/`mem_dout`/`mem_a`/`mem_wr`). It replaces the fixed two-fetch-port-plus-one-LS front end of the cache with a configurable channel count and a selectable arbitration mode. It pipelines read addresses against the 2-cycle memory read latency and honours `rdy` without replaying I/O accesses.

---
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//
// Multi-channel front end for a byte-wide external memory. Each of NCH
// requesters posts a 1/2/4-byte load or store. One request is accepted at a
// time and serialised onto the byte bus. Read addresses are issued
// back-to-back ahead of the 2-cycle memory read latency, and returning bytes
// are captured as they arrive.
//
// Parameters
//   NCH      number of request channels (channel 0 = highest fixed priority)
//   RR_MODE  0 = fixed priority, 1 = round-robin
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   rdy          bus enable; when low nothing new is presented on the bus
//   req/we       per-channel request level and write flag
//   addr/wdata   per-channel byte address and little-endian write data (32b each)
//   size         per-channel size code: 0 -> 1B, 1 -> 2B, 3 -> 4B, 2 -> 1B
//   done         one-hot, one-cycle completion pulse
//   rdata        zero-extended read result, valid while done is high
//   busy         controller is not idle
//   mem_din      memory read data
//   mem_dout     memory write data
//   mem_a/mem_wr memory address and write strobe
// ---------------------------------------------------------------------------
module mem_ctrl #(
  parameter int NCH     = 3,
  parameter bit RR_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [32*NCH-1:0] addr,
  input  logic [2*NCH-1:0]  size,
  input  logic [32*NCH-1:0] wdata,
  output logic [NCH-1:0]    done,
  output logic [31:0]       rdata,
  output logic              busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q;        // channel being served
  logic [CW-1:0]   last_q;      // last-served channel (round-robin pointer)
  logic [CW-1:0]   pick;
  logic            pick_vld;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      n_q;         // byte count 1/2/4
  logic [2:0]      i_q;         // bytes issued on the bus
  logic [2:0]      j_q;         // read bytes captured
  logic            pend_q;      // a read byte was issued last cycle
  logic            issue;

  function automatic logic [2:0] n_bytes(input logic [1:0] s);
    case (s)
      2'd1:    return 3'd2;
      2'd3:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Arbiter. In round-robin mode the scan starts just after the last-served
  // channel; iterating the offset downwards lets the nearest requester win.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    if (RR_MODE) begin
      for (int k = NCH; k >= 1; k--) begin
        if (req[(int'(last_q) + k) % NCH]) begin
          pick     = CW'((int'(last_q) + k) % NCH);
          pick_vld = 1'b1;
        end
      end
    end else begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (req[c]) begin
          pick     = CW'(c);
          pick_vld = 1'b1;
        end
      end
    end
  end

  // A byte goes out on the bus only in an rdy-high cycle; reads stop issuing
  // once all n addresses are out but stay in RD until the data is back.
  assign issue = rdy && ((state_q == WR) || (state_q == RD && i_q < n_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rdy && pick_vld) state_d = we[pick] ? WR : RD;
      WR:   if (issue && (i_q + 3'd1 == n_q)) state_d = DONE;
      // Completion follows the returning data, so it does not wait for rdy.
      RD:   if (pend_q && (j_q + 3'd1 == n_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= CW'(NCH - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      pend_q  <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      // Memory keeps returning data while rdy is low, so pend always tracks.
      pend_q  <= issue && (state_q == RD);
      if (state_q == IDLE && rdy && pick_vld) begin
        ch_q    <= pick;
        last_q  <= pick;
        addr_q  <= addr[32*pick +: 32];
        wdata_q <= wdata[32*pick +: 32];
        n_q     <= n_bytes(size[2*pick +: 2]);
        i_q     <= '0;
        j_q     <= '0;
        rdata   <= '0;            // unused upper bytes read back as zero
      end else begin
        if (issue) i_q <= i_q + 3'd1;
        if (state_q == RD && pend_q) begin
          rdata[{j_q[1:0], 3'b000} +: 8] <= mem_din;
          j_q <= j_q + 3'd1;
        end
      end
    end
  end

  // Bus outputs are gated by rdy, so a paused cycle never repeats a write
  // or re-reads an I/O location.
  assign mem_a    = issue ? (addr_q + {29'd0, i_q}) : '0;
  assign mem_wr   = issue && (state_q == WR);
  assign mem_dout = (state_q == WR) ? wdata_q[{i_q[1:0], 3'b000} +: 8] : '0;
  assign busy     = (state_q != IDLE);

  always_comb begin
    done = '0;
    if (state_q == DONE) done[ch_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//
// Two controller instances (fixed priority and round-robin) share stimulus;
// `sel` routes requests to one of them at a time. A byte-wide memory with a
// registered read port sits on the selected instance's bus. A transaction-
// level reference model predicts bus activity, done timing and read data
// from the transfer rules; a compare process checks every cycle. Directed
// scenarios add literal expectations on the recorded bus and done events.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int NCH = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b0;
  logic              sel = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    we = '0;
  logic [32*NCH-1:0] addr = '0;
  logic [2*NCH-1:0]  size = '0;
  logic [32*NCH-1:0] wdata = '0;
  logic [7:0]        mem_din = '0;

  logic [NCH-1:0] req_f, req_r, done_f, done_r, d_done;
  logic [31:0]    rdata_f, rdata_r, mem_a_f, mem_a_r, d_rdata, d_mem_a;
  logic [7:0]     dout_f, dout_r, d_mem_dout;
  logic           busy_f, busy_r, wr_f, wr_r, d_busy, d_mem_wr;

  assign req_f = sel ? '0 : req;
  assign req_r = sel ? req : '0;

  mem_ctrl #(.NCH(NCH), .RR_MODE(1'b0)) u_fix (
    .clk(clk), .rst(rst), .rdy(rdy), .req(req_f), .we(we), .addr(addr),
    .size(size), .wdata(wdata), .done(done_f), .rdata(rdata_f), .busy(busy_f),
    .mem_din(mem_din), .mem_dout(dout_f), .mem_a(mem_a_f), .mem_wr(wr_f)
  );

  mem_ctrl #(.NCH(NCH), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .req(req_r), .we(we), .addr(addr),
    .size(size), .wdata(wdata), .done(done_r), .rdata(rdata_r), .busy(busy_r),
    .mem_din(mem_din), .mem_dout(dout_r), .mem_a(mem_a_r), .mem_wr(wr_r)
  );

  assign d_done     = sel ? done_r  : done_f;
  assign d_rdata    = sel ? rdata_r : rdata_f;
  assign d_busy     = sel ? busy_r  : busy_f;
  assign d_mem_a    = sel ? mem_a_r : mem_a_f;
  assign d_mem_wr   = sel ? wr_r    : wr_f;
  assign d_mem_dout = sel ? dout_r  : dout_f;

  always #5 clk = ~clk;

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  logic [7:0] env_mem [bit [31:0]];   // what the bus actually wrote
  logic [7:0] ref_mem [bit [31:0]];   // what the model says was written

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    env_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Memory: write on the edge, read data registered (available next cycle).
  logic [31:0] bus_a_s  = '0;
  logic        bus_wr_s = 1'b0;
  logic [7:0]  bus_d_s  = '0;

  always @(negedge clk) begin
    bus_a_s  = d_mem_a;
    bus_wr_s = d_mem_wr;
    bus_d_s  = d_mem_dout;
  end

  always @(posedge clk) begin
    if (bus_wr_s) env_mem[bus_a_s] = bus_d_s;
    mem_din <= env_rd(bus_a_s);
  end

  // ---------------- reference model ----------------
  bit             m_active = 1'b0;
  int             m_ch, m_n, m_issued, m_done_at;
  bit             m_we;
  logic [31:0]    m_addr, m_wdata, m_rdata;
  int             rr_last = NCH - 1;
  logic [NCH-1:0] last_done = '0;
  int             nbytes_of [4] = '{1, 2, 1, 4};

  function automatic int winner(input logic [NCH-1:0] r, input int last, input bit rr);
    if (rr) begin
      for (int k = 1; k <= NCH; k++)
        if (r[(last + k) % NCH]) return (last + k) % NCH;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (r[c]) return c;
    end
    return -1;
  endfunction

  typedef struct { int c; logic [31:0] a; logic wr; logic [7:0] d; } bus_ev_t;
  typedef struct { int c; logic [NCH-1:0] dn; logic [31:0] rd; } done_ev_t;
  bus_ev_t  bus_log[$];
  done_ev_t done_log[$];

  // Compare process: expected outputs for this cycle, then advance the model.
  always @(negedge clk) begin
    logic [NCH-1:0] e_done;
    logic           e_busy, e_wr;
    logic [31:0]    e_a;
    logic [7:0]     e_dout;
    int             w;
    if (rst) begin
      check("rst_busy", {31'd0, d_busy}, 32'd0);
      check("rst_done", {29'd0, d_done}, 32'd0);
      check("rst_mem_a", d_mem_a, 32'd0);
      check("rst_mem_wr", {31'd0, d_mem_wr}, 32'd0);
      check("rst_rdata", d_rdata, 32'd0);
      m_active  = 1'b0;
      rr_last   = NCH - 1;
      last_done = '0;
    end else begin
      e_done = '0; e_busy = 1'b0; e_wr = 1'b0; e_a = '0; e_dout = '0;
      if (m_active) begin
        e_busy = 1'b1;
        if (cyc == m_done_at) e_done[m_ch] = 1'b1;
        else if (m_issued < m_n && rdy) begin
          e_a    = m_addr + 32'(m_issued);
          e_wr   = m_we;
          e_dout = m_wdata[8*m_issued +: 8];
        end
      end
      check("busy", {31'd0, d_busy}, {31'd0, e_busy});
      check("done", {29'd0, d_done}, {29'd0, e_done});
      check("mem_a", d_mem_a, e_a);
      check("mem_wr", {31'd0, d_mem_wr}, {31'd0, e_wr});
      if (e_wr) check("mem_dout", {24'd0, d_mem_dout}, {24'd0, e_dout});
      if (e_done != '0 && !m_we) check("rdata", d_rdata, m_rdata);

      if (d_mem_wr || d_mem_a != '0) bus_log.push_back('{cyc, d_mem_a, d_mem_wr, d_mem_dout});
      if (d_done != '0) done_log.push_back('{cyc, d_done, d_rdata});
      last_done = e_done;

      if (m_active) begin
        if (cyc == m_done_at) m_active = 1'b0;
        else if (m_issued < m_n && rdy) begin
          if (m_we) ref_mem[e_a] = e_dout;
          m_issued++;
          // Writes finish on the edge of the last byte; reads need the data
          // from the last address, which arrives two edges later.
          if (m_issued == m_n) m_done_at = cyc + (m_we ? 1 : 2);
        end
      end else if (rdy && req != '0) begin
        w         = winner(req, rr_last, sel);
        rr_last   = w;
        m_ch      = w;
        m_we      = we[w];
        m_addr    = addr[32*w +: 32];
        m_wdata   = wdata[32*w +: 32];
        m_n       = nbytes_of[size[2*w +: 2]];
        m_issued  = 0;
        m_done_at = -1;
        m_active  = 1'b1;
        m_rdata   = '0;
        for (int b = 0; b < m_n; b++) m_rdata[8*b +: 8] = ref_rd(m_addr + 32'(b));
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  // Advance one cycle; requesters drop req on the edge after their done.
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~last_done;
  endtask

  task automatic set_ch(input int c, input bit w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
    we[c]             = w;
    addr[32*c +: 32]  = a;
    size[2*c +: 2]    = s;
    wdata[32*c +: 32] = d;
    req[c]            = 1'b1;
  endtask

  task automatic wait_dones(input int cnt, input int budget, input string nm);
    int k;
    k = 0;
    while (done_log.size() < cnt && k < budget) begin
      step();
      k++;
    end
    check({nm, "_timeout"}, done_log.size(), cnt);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    bus_log.delete();
    done_log.delete();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 31));
      1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      2:       return 32'h0003_0000 + 32'($urandom_range(0, 7));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_phase(input int ncyc);
    int k;
    for (int n = 0; n < ncyc; n++) begin
      step();
      rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++)
        if (!req[c] && !last_done[c] && $urandom_range(0, 3) == 0)
          set_ch(c, 1'($urandom_range(0, 1)), rand_addr(),
                 2'($urandom_range(0, 3)), $urandom());
    end
    rdy = 1'b1;
    k = 0;
    while (req != '0 && k < 200) begin
      step();
      k++;
    end
    check("drain", {29'd0, req}, 32'd0);
    repeat (3) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit again;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy_f}, 32'd0);
    check("reset_done", {29'd0, done_f}, 32'd0);
    check("reset_mem_a", mem_a_f, 32'd0);
    check("reset_mem_wr", {31'd0, wr_f}, 32'd0);
    check("reset_mem_dout", {24'd0, dout_f}, 32'd0);
    check("reset_rdata", rdata_f, 32'd0);
    rst = 1'b0;
    rdy = 1'b1;
    step(); step();

    // 4-byte read, channel 0
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    clear_logs();
    set_ch(0, 1'b0, 32'h100, 2'd3, 32'h0);
    wait_dones(1, 30, "rd4");
    check("rd4_nbus", bus_log.size(), 4);
    if (bus_log.size() == 4 && done_log.size() == 1) begin
      for (int b = 0; b < 4; b++) begin
        check("rd4_addr", bus_log[b].a, 32'h100 + 32'(b));
        check("rd4_slot", bus_log[b].c - bus_log[0].c, b);
      end
      check("rd4_ch", {29'd0, done_log[0].dn}, 32'b001);
      check("rd4_rdata", done_log[0].rd, 32'h4433_2211);
      check("rd4_latency", done_log[0].c - bus_log[0].c, 5);
    end

    // 2-byte write, channel 1
    clear_logs();
    set_ch(1, 1'b1, 32'h200, 2'd1, 32'h0000_BEEF);
    wait_dones(1, 30, "wr2");
    check("wr2_nbus", bus_log.size(), 2);
    if (bus_log.size() == 2 && done_log.size() == 1) begin
      check("wr2_a0", bus_log[0].a, 32'h200);
      check("wr2_d0", {24'd0, bus_log[0].d}, 32'hEF);
      check("wr2_w0", {31'd0, bus_log[0].wr}, 32'd1);
      check("wr2_a1", bus_log[1].a, 32'h201);
      check("wr2_d1", {24'd0, bus_log[1].d}, 32'hBE);
      check("wr2_ch", {29'd0, done_log[0].dn}, 32'b010);
      check("wr2_latency", done_log[0].c - bus_log[0].c, 2);
    end

    // I/O 1-byte read, rdy low on the cycle after issue
    preload(32'h0003_0000, 8'h5C);
    clear_logs();
    set_ch(0, 1'b0, 32'h0003_0000, 2'd0, 32'h0);
    step();
    step(); rdy = 1'b0;
    step(); rdy = 1'b1;
    wait_dones(1, 30, "io");
    check("io_nbus", bus_log.size(), 1);
    if (bus_log.size() == 1 && done_log.size() == 1) begin
      check("io_addr", bus_log[0].a, 32'h0003_0000);
      check("io_rdata", done_log[0].rd, 32'h5C);
      check("io_latency", done_log[0].c - bus_log[0].c, 2);
    end

    // 4-byte read with a 3-cycle pause after the first address
    preload(32'h40, 8'hA1); preload(32'h41, 8'hB2);
    preload(32'h42, 8'hC3); preload(32'h43, 8'hD4);
    clear_logs();
    set_ch(2, 1'b0, 32'h40, 2'd3, 32'h0);
    step();
    step(); rdy = 1'b0;
    step();
    step();
    step(); rdy = 1'b1;
    wait_dones(1, 30, "pause");
    check("pause_nbus", bus_log.size(), 4);
    if (bus_log.size() == 4 && done_log.size() == 1) begin
      for (int b = 0; b < 4; b++) check("pause_addr", bus_log[b].a, 32'h40 + 32'(b));
      check("pause_gap", bus_log[1].c - bus_log[0].c, 4);
      check("pause_ch", {29'd0, done_log[0].dn}, 32'b100);
      check("pause_rdata", done_log[0].rd, 32'hD4C3_B2A1);
      check("pause_latency", done_log[0].c - bus_log[0].c, 8);
    end

    // Reset in the middle of a read
    set_ch(0, 1'b0, 32'h100, 2'd3, 32'h0);
    step();
    step();
    step();
    rst = 1'b1;
    req = '0;
    #1;
    check("abort_busy", {31'd0, busy_f}, 32'd0);
    check("abort_mem_a", mem_a_f, 32'd0);
    check("abort_mem_wr", {31'd0, wr_f}, 32'd0);
    check("abort_rdata", rdata_f, 32'd0);
    step(); step();
    rst = 1'b0;
    clear_logs();
    repeat (4) step();
    check("abort_no_done", done_log.size(), 0);
    set_ch(1, 1'b0, 32'h102, 2'd0, 32'h0);
    wait_dones(1, 30, "after_rst");
    if (done_log.size() == 1) begin
      check("after_rst_ch", {29'd0, done_log[0].dn}, 32'b010);
      check("after_rst_rdata", done_log[0].rd, 32'h33);
    end

    // Fixed-priority arbitration
    clear_logs();
    set_ch(0, 1'b0, 32'h10, 2'd0, 32'h0);
    set_ch(1, 1'b0, 32'h11, 2'd0, 32'h0);
    set_ch(2, 1'b0, 32'h12, 2'd0, 32'h0);
    wait_dones(3, 60, "fix_arb");
    if (done_log.size() == 3 && bus_log.size() >= 2) begin
      check("fix_order0", {29'd0, done_log[0].dn}, 32'b001);
      check("fix_order1", {29'd0, done_log[1].dn}, 32'b010);
      check("fix_order2", {29'd0, done_log[2].dn}, 32'b100);
      check("fix_gap", bus_log[1].c - done_log[0].c, 2);
    end

    rand_phase(1500);

    // Switch to the round-robin instance
    rst = 1'b1;
    sel = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    clear_logs();
    set_ch(0, 1'b0, 32'h20, 2'd0, 32'h0);
    set_ch(1, 1'b0, 32'h21, 2'd0, 32'h0);
    set_ch(2, 1'b0, 32'h22, 2'd0, 32'h0);
    again = 1'b0;
    k = 0;
    while (done_log.size() < 4 && k < 80) begin
      step();
      k++;
      if (!again && done_log.size() >= 1 && cyc > done_log[0].c + 1) begin
        set_ch(0, 1'b0, 32'h23, 2'd0, 32'h0);
        again = 1'b1;
      end
    end
    check("rr_timeout", done_log.size(), 4);
    if (done_log.size() == 4) begin
      check("rr_order0", {29'd0, done_log[0].dn}, 32'b001);
      check("rr_order1", {29'd0, done_log[1].dn}, 32'b010);
      check("rr_order2", {29'd0, done_log[2].dn}, 32'b100);
      check("rr_order3", {29'd0, done_log[3].dn}, 32'b001);
    end
    repeat (3) step();

    rand_phase(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
